e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage. Consumes the operands and decoded instruction held by the D→E pipeline register (E_RD1, E_RD2, E_command decode).
- Owns the architectural HI/LO registers. Models multi-cycle latency and drives a busy/start pair used by the D-stage hazard unit to stall md-type instructions.
- Supplies the mfhi/mflo read value, which flows onward to the E→M register.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
clk  input  1  clock
res  input  1  reset, synchronous, active-high
req  input  1  exception/interrupt flush this cycle; blocks new start and mthi/mtlo writes
md_op  input  4  decoded op of E-stage instruction (encodings in package)
A  input  32  rs operand (forwarded E_RD1)
B  input  32  rt operand (forwarded E_RD2)
start  output  1  combinational: md_op ∈ {MULT,MULTU,DIV,DIVU} && !req && !busy
busy  output  1  registered: operation in flight
HI_out  output  32  architectural HI
LO_out  output  32  architectural LO
md_out  output  32  combinational: HI_out if MFHI, LO_out if MFLO, else 0

Behaviour:
- Reset (res=1 at posedge), regardless of state: HI=0, LO=0, busy=0, counter=0, pending HI/LO temps=0. Any in-flight op is discarded.
- Start:
  - At the posedge where start=1, latch the result into temp_hi/temp_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and set busy=1.
- Busy countdown:
  - busy stays high for exactly N cycles after the start edge.
  - Counter decrements each cycle.
  - On the edge where the counter goes 1→0: HI<=temp_hi, LO<=temp_lo, busy<=0.
  - HI/LO stay at old values for the whole busy window.
- Back-to-back: a new start is possible in the cycle busy is first low (start cycle t, N=5: busy t+1..t+5, result visible t+6, next start may assert at t+6).
- mult/multu: {HI,LO} = 64-bit product of A and B, signed or unsigned respectively.
- div (signed):
  - LO = quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0):
  - Timing is unchanged; busy is asserted for DIV_CYCLES.
  - At completion HI/LO keep their pre-start values, i.e. no write.
- mthi/mtlo:
  - When !req && !busy, HI<=A (MTHI) or LO<=A (MTLO) at the next edge, single cycle.
  - Ignored while busy; the hazard unit guarantees this does not occur.
- md-type op arriving while busy:
  - Ignored; start is forced 0.
  - The D stage stalls any md-type instruction while (start||busy), so this is defensive only.
- req=1:
  - Suppresses start and mthi/mtlo in that cycle (the E instruction is being flushed).
  - Does NOT cancel an in-flight operation: it belongs to an older, committed instruction and completes normally.
- md_out reflects architectural HI/LO only (no bypass of temp). mfhi/mflo are stalled upstream while start||busy.
- Simultaneous start and res: res wins.

Decomposition:
- Shared package:
  - md_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Default cycle constants.
  - Helper is_md_start(op).
- No sub-module: the result computation is a combinational block inside e_mdu, and the countdown FSM (IDLE/BUSY via counter≠0) is inline.

Test Plan:
- A=0xFFFFFFFE, B=3, MULT with start at t: busy=1 t+1..t+5. At t+6, HI=0xFFFFFFFF, LO=0xFFFFFFFA. HI/LO unchanged before t+6.
- MULTU, same operands: at t+6, HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 after MTHI 0x11, MTLO 0x22: busy 10 cycles, then HI=0x11, LO=0x22.
- MULT in flight, req=1 at t+2 with md_op=MTLO A=5: LO not written by MTLO, MULT still completes at t+6 with the correct product. MULT presented with req=1: start=0, busy stays 0.
- res=1 at t+3 of a DIV: next cycle busy=0, HI=LO=0, no later write. MFHI/MFLO give md_out=HI_out/LO_out; NONE gives md_out=0.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// operation encodings, default latencies and the start-classification helper.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multiply/divide unit: owns HI/LO, models multi-cycle latency with a
// countdown, and exposes busy/start for the decode-stage stall logic.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] md_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic        wr_q, wr_d;

    // Result datapath
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic        [31:0] a_mag, b_mag;
    logic        [31:0] q_mag, r_mag;
    logic        [31:0] q_s, r_s;
    logic        [31:0] q_u, r_u;
    logic        [31:0] res_hi, res_lo;
    logic               div_by_zero;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};

        // Signed divide via magnitudes so MIN/-1 wraps to MIN with zero remainder.
        b_safe = (B == '0) ? 32'd1 : B;
        a_mag  = A[31] ? (32'd0 - A) : A;
        b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
        r_s    = A[31] ? (32'd0 - r_mag) : r_mag;
        q_u    = A / b_safe;
        r_u    = A % b_safe;

        res_hi = '0;
        res_lo = '0;
        case (md_op)
            MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            MD_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            MD_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  ;
        endcase

        div_by_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (B == '0);
    end

    assign busy   = (state_q == ST_BUSY);
    assign start  = is_md_start(md_op) && !req && !busy;
    assign HI_out = hi_q;
    assign LO_out = lo_q;

    always_comb begin
        md_out = '0;
        if (md_op == MD_MFHI) md_out = hi_q;
        else if (md_op == MD_MFLO) md_out = lo_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        wr_d     = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    wr_d     = !div_by_zero;
                    state_d  = ST_BUSY;
                    if ((md_op == MD_MULT) || (md_op == MD_MULTU))
                        cnt_d = 32'(MULT_CYCLES);
                    else
                        cnt_d = 32'(DIV_CYCLES);
                end else if (!req && (md_op == MD_MTHI)) begin
                    hi_d = A;
                end else if (!req && (md_op == MD_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            wr_q     <= wr_d;
        end
    end

endmodule
